// File: rtl/uart_led_cmd_pkg.sv
// Shared types and constants for the UART LED command controller.
package uart_led_cmd_pkg;

  typedef enum logic [1:0] {IDLE, PAYLOAD, SEND, READ} state_t;

  localparam logic [7:0] CMD_WR_U    = 8'h53;
  localparam logic [7:0] CMD_WR_L    = 8'h73;
  localparam logic [7:0] CMD_RD_U    = 8'h52;
  localparam logic [7:0] CMD_RD_L    = 8'h72;
  localparam logic [7:0] ACK_DEFAULT = 8'h41;
  localparam logic [7:0] NAK_DEFAULT = 8'h4E;

endpackage

// File: rtl/uart_tx_sequencer.sv
// Paces bytes into the uart: one-cycle TX_ENABLE when idle, then two guard
// cycles before the uart's idle flag is trusted again.
module uart_tx_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       tx_idle,
  output logic [7:0] tx_data,
  output logic       tx_enable,
  output logic       done
);

  logic [1:0] guard;

  // done doubles as the fire strobe; the requester advances on the same edge
  assign done = req && (guard == 2'd0) && tx_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data   <= 8'h00;
      tx_enable <= 1'b0;
      guard     <= 2'd0;
    end else begin
      tx_enable <= done;
      if (done) begin
        tx_data <= data;
        guard   <= 2'd2;
      end else if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end
    end
  end

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Write/read command controller for a multi-byte LED register over the uart.
// Define UART_LED_CMD_CHECKSUM_EN to add an XOR checksum byte in both directions.
module uart_led_cmd_ctrl
  import uart_led_cmd_pkg::*;
#(
  parameter int         LED_W          = 8,
  parameter int         TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0] ACK_CHAR       = ACK_DEFAULT,
  parameter logic [7:0] NAK_CHAR       = NAK_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       RX_DATA,
  input  logic             RX_READY,
  input  logic             TX_IDLE,
  output logic [7:0]       TX_DATA,
  output logic             TX_ENABLE,
  output logic [LED_W-1:0] LED,
  output logic             BUSY
);

  localparam int NB = LED_W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef UART_LED_CMD_CHECKSUM_EN
  localparam int LAST = NB;
`else
  localparam int LAST = NB - 1;
`endif

  state_t           state;
  logic [LED_W-1:0] shadow;
  logic [LED_W+7:0] shifted;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;
  logic [7:0]       tx_byte;
  logic [7:0]       seq_data;
  logic             req;
  logic             done;
`ifdef UART_LED_CMD_CHECKSUM_EN
  logic [7:0]       chk;
`endif

  assign shifted = {shadow, RX_DATA};
  assign req     = (state == SEND) || (state == READ);
  assign BUSY    = (state != IDLE);

  always_comb begin
    seq_data = shadow[LED_W-1 -: 8];
    if (state == SEND) seq_data = tx_byte;
`ifdef UART_LED_CMD_CHECKSUM_EN
    else if (cnt == CW'(NB)) seq_data = chk;
`endif
  end

  // shadow holds the incoming payload in PAYLOAD and the LED snapshot in READ
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      LED     <= '0;
      shadow  <= '0;
      cnt     <= '0;
      timer   <= '0;
      tx_byte <= 8'h00;
`ifdef UART_LED_CMD_CHECKSUM_EN
      chk     <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: if (RX_READY) begin
          cnt   <= '0;
          timer <= '0;
`ifdef UART_LED_CMD_CHECKSUM_EN
          chk   <= 8'h00;
`endif
          if (RX_DATA == CMD_WR_U || RX_DATA == CMD_WR_L) begin
            state  <= PAYLOAD;
            shadow <= '0;
          end else if (RX_DATA == CMD_RD_U || RX_DATA == CMD_RD_L) begin
            state  <= READ;
            shadow <= LED;
          end else begin
            LED <= '0;
          end
        end
        PAYLOAD: if (RX_READY) begin
          timer <= '0;
          cnt   <= cnt + CW'(1);
`ifdef UART_LED_CMD_CHECKSUM_EN
          if (cnt == CW'(NB)) begin
            state <= SEND;
            if (RX_DATA == chk) begin
              LED     <= shadow;
              tx_byte <= ACK_CHAR;
            end else begin
              tx_byte <= NAK_CHAR;
            end
          end else begin
            shadow <= shifted[LED_W-1:0];
            chk    <= chk ^ RX_DATA;
          end
`else
          shadow <= shifted[LED_W-1:0];
          if (cnt == CW'(NB - 1)) begin
            LED     <= shifted[LED_W-1:0];
            tx_byte <= ACK_CHAR;
            state   <= SEND;
          end
`endif
        end else if (timer == TW'(TIMEOUT_CYCLES)) begin
          shadow  <= '0;
          tx_byte <= NAK_CHAR;
          state   <= SEND;
        end else begin
          timer <= timer + TW'(1);
        end
        SEND: if (done) state <= IDLE;
        READ: if (done) begin
          cnt    <= cnt + CW'(1);
          shadow <= shadow << 8;
`ifdef UART_LED_CMD_CHECKSUM_EN
          chk    <= chk ^ shadow[LED_W-1 -: 8];
`endif
          if (cnt == CW'(LAST)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_sequencer u_tx_seq (
    .clk      (CLK),
    .rst      (RST),
    .req      (req),
    .data     (seq_data),
    .tx_idle  (TX_IDLE),
    .tx_data  (TX_DATA),
    .tx_enable(TX_ENABLE),
    .done     (done)
  );

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Directed bench for uart_led_cmd_ctrl (LED_W=16, TIMEOUT_CYCLES=1000) with a
// uart model whose idle flag drops for 50 cycles after every TX_ENABLE.
module tb_uart_led_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        tx_idle = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic [15:0] led;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int npulse = 0;
  int bad_pulses = 0;
  int idle_cnt = 0;
  logic [7:0] txlog[$];

  typedef struct {
    int          n;
    logic [31:0] b;
    logic [15:0] led;
    int          np;
    logic [23:0] tx;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   base;

  uart_led_cmd_ctrl #(.LED_W(16), .TIMEOUT_CYCLES(1000)) dut (
    .CLK(clk), .RST(rst), .RX_DATA(rx_data), .RX_READY(rx_ready),
    .TX_IDLE(tx_idle), .TX_DATA(tx_data), .TX_ENABLE(tx_enable),
    .LED(led), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // uart model: logs each pulse and goes busy for 50 cycles
  always @(negedge clk) begin
    if (rst) begin
      idle_cnt = 0;
      tx_idle  = 1'b1;
    end else if (tx_enable) begin
      if (!tx_idle) bad_pulses++;
      txlog.push_back(tx_data);
      npulse++;
      tx_idle  = 1'b0;
      idle_cnt = 50;
    end else if (idle_cnt > 0) begin
      idle_cnt--;
      if (idle_cnt == 0) tx_idle = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] v);
    send_byte(8'h53);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
`ifdef UART_LED_CMD_CHECKSUM_EN
    send_byte(v[15:8] ^ v[7:0]);
`endif
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", k);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] logged(input int idx);
    if (idx < txlog.size()) return txlog[idx];
    return 8'hxx;
  endfunction

  initial begin
`ifdef UART_LED_CMD_CHECKSUM_EN
    vecs.push_back('{4, 32'h53123426, 16'h1234, 1, 24'h410000});
    vecs.push_back('{1, 32'h72000000, 16'h1234, 3, 24'h123426});
    vecs.push_back('{1, 32'h78000000, 16'h0000, 0, 24'h000000});
    vecs.push_back('{4, 32'h53000101, 16'h0001, 1, 24'h410000});
    vecs.push_back('{4, 32'h73FFA55A, 16'hFFA5, 1, 24'h410000});
    vecs.push_back('{4, 32'h53123400, 16'hFFA5, 1, 24'h4E0000});
    vecs.push_back('{1, 32'h52000000, 16'hFFA5, 3, 24'hFFA55A});
`else
    vecs.push_back('{3, 32'h53123400, 16'h1234, 1, 24'h410000});
    vecs.push_back('{1, 32'h72000000, 16'h1234, 2, 24'h123400});
    vecs.push_back('{1, 32'h78000000, 16'h0000, 0, 24'h000000});
    vecs.push_back('{3, 32'h53000100, 16'h0001, 1, 24'h410000});
    vecs.push_back('{3, 32'h73FFA500, 16'hFFA5, 1, 24'h410000});
    vecs.push_back('{1, 32'h52000000, 16'hFFA5, 2, 24'hFFA500});
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_led", led, 0);
    check("reset_tx_enable", tx_enable, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_busy", busy, 0);

    for (int v = 0; v < vecs.size(); v++) begin
      cur  = vecs[v];
      base = npulse;
      for (int i = 0; i < cur.n; i++) send_byte(cur.b[31-8*i -: 8]);
      check($sformatf("v%0d_led_latency", v), led, cur.led);
      wait_idle();
      check($sformatf("v%0d_led", v), led, cur.led);
      check($sformatf("v%0d_pulses", v), npulse - base, cur.np);
      for (int j = 0; j < cur.np; j++)
        check($sformatf("v%0d_tx%0d", v, j), logged(base + j), cur.tx[23-8*j -: 8]);
      check($sformatf("v%0d_busy_end", v), busy, 0);
      check($sformatf("v%0d_no_pulse_while_busy", v), bad_pulses, 0);
    end

    // inter-byte timeout aborts the write with NAK
    base = npulse;
    send_byte(8'h53);
    send_byte(8'hAB);
    repeat (990) @(negedge clk);
    check("timeout_not_early_pulses", npulse - base, 0);
    check("timeout_not_early_busy", busy, 1);
    wait_idle();
    check("timeout_pulses", npulse - base, 1);
    check("timeout_nak", logged(base), 8'h4E);
    check("timeout_led_kept", led, 16'hFFA5);

    base = npulse;
    write_word(16'h0001);
    wait_idle();
    check("after_timeout_led", led, 16'h0001);
    check("after_timeout_pulses", npulse - base, 1);
    check("after_timeout_ack", logged(base), 8'h41);

    // asynchronous reset between payload bytes
    send_byte(8'h53);
    send_byte(8'h12);
    #2 rst = 1'b1;
    #1;
    check("midreset_led", led, 0);
    check("midreset_tx_enable", tx_enable, 0);
    check("midreset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = npulse;
    write_word(16'hBEEF);
    check("postreset_led_latency", led, 16'hBEEF);
    wait_idle();
    check("postreset_led", led, 16'hBEEF);
    check("postreset_pulses", npulse - base, 1);
    check("postreset_ack", logged(base), 8'h41);
    check("no_pulse_while_busy_final", bad_pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
